// File: rtl/conv1_window_scheduler.sv
// Window scheduler for the first conv layer: drives the stride-2 window fetcher frame by frame,
// buffers fetched windows in a small skid FIFO and streams them to the PE array.
module conv1_window_scheduler #(
    parameter int IMG_W      = 224,
    parameter int IMG_H      = 224,
    parameter int STRIDE     = 2,
    parameter int A_BITS     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 layer_start,
    input  logic [7:0]           num_frames,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err_timeout,
    output logic                 err_seq,
    output logic                 fw_start_frame,
    output logic                 fw_win_req,
    input  logic                 fw_win_valid,
    input  logic [27*A_BITS-1:0] fw_win_flat,
    input  logic                 fw_frame_done,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [27*A_BITS-1:0] m_data,
    output logic                 m_last,
    output logic [15:0]          m_win_idx
);
    localparam int WW = 27 * A_BITS;
    localparam int NUM_WIN = (IMG_W / STRIDE) * (IMG_H / STRIDE);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] NUM_WIN16 = 16'(NUM_WIN);
    localparam logic [15:0] LAST_IDX = 16'(NUM_WIN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    state_t          state_r, state_s;
    logic [7:0]      frames_r, frame_cnt_r;
    logic            busy_r, layer_done_r, err_timeout_r, err_seq_r;
    logic [15:0]     issue_cnt_r, recv_cnt_r;
    logic            outst_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [WW-1:0]   fifo_data_r [FIFO_DEPTH];
    logic            fifo_last_r [FIFO_DEPTH];
    logic [15:0]     fifo_idx_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   fifo_cnt_r;
    logic            accept_s, pop_s, push_s, issue_req_s, timeout_s, fd_expect_s, seq_err_s;
    logic            start_acc_s, drain_done_s, last_frame_s, fifo_ne_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) return {PW{1'b0}};
        else return p + PW'(1);
    endfunction

    // Handshake qualifiers; a request needs a free FIFO slot counted without any same-cycle pop.
    always_comb begin
        fifo_ne_s    = (fifo_cnt_r != {CW{1'b0}});
        accept_s     = fw_win_valid && outst_r;
        pop_s        = fifo_ne_s && m_ready;
        push_s       = accept_s && ((fifo_cnt_r != FULL_CNT) || pop_s);
        issue_req_s  = (state_r == RUN) && (issue_cnt_r < NUM_WIN16) && !outst_r &&
                       (fifo_cnt_r < FULL_CNT) && !fw_win_valid;
        timeout_s    = outst_r && !fw_win_valid && (tmo_cnt_r >= TW'(TIMEOUT - 1));
        fd_expect_s  = accept_s && (recv_cnt_r == LAST_IDX);
        seq_err_s    = (fw_win_valid && !outst_r) || (fw_frame_done != fd_expect_s);
        start_acc_s  = (state_r == IDLE) && layer_start;
        drain_done_s = (state_r == DRAIN) && !fifo_ne_s;
        last_frame_s = ({1'b0, frame_cnt_r} + 9'd1) >= {1'b0, frames_r};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:  if (layer_start) state_s = START; else state_s = IDLE;
            START: state_s = RUN;
            RUN: begin
                if (timeout_s) state_s = IDLE;
                else if (recv_cnt_r == NUM_WIN16) state_s = DRAIN;
                else state_s = RUN;
            end
            DRAIN: begin
                if (fifo_ne_s) state_s = DRAIN;
                else if (last_frame_s) state_s = IDLE;
                else state_s = START;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state_r <= IDLE;
        else state_r <= state_s;
    end

    // Layer/frame bookkeeping, request credit, timeout and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frames_r      <= 8'd0;
            frame_cnt_r   <= 8'd0;
            busy_r        <= 1'b0;
            layer_done_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            err_seq_r     <= 1'b0;
            issue_cnt_r   <= 16'd0;
            recv_cnt_r    <= 16'd0;
            outst_r       <= 1'b0;
            tmo_cnt_r     <= {TW{1'b0}};
        end else begin
            layer_done_r <= drain_done_s && last_frame_s;
            if (start_acc_s) begin
                frames_r      <= (num_frames == 8'd0) ? 8'd1 : num_frames;
                frame_cnt_r   <= 8'd0;
                busy_r        <= 1'b1;
                err_timeout_r <= 1'b0;
                err_seq_r     <= seq_err_s;
            end else begin
                if (seq_err_s) err_seq_r <= 1'b1;
                if (timeout_s) begin
                    err_timeout_r <= 1'b1;
                    busy_r        <= 1'b0;
                end else if (drain_done_s) begin
                    if (last_frame_s) busy_r <= 1'b0;
                    else frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end
            if (state_r == START) begin
                issue_cnt_r <= 16'd0;
                recv_cnt_r  <= 16'd0;
            end
            // tmo_cnt_r holds cycles elapsed since the outstanding request was issued
            if (issue_req_s) begin
                outst_r     <= 1'b1;
                issue_cnt_r <= issue_cnt_r + 16'd1;
                tmo_cnt_r   <= TW'(1);
            end else if (accept_s || timeout_s) begin
                outst_r <= 1'b0;
            end else if (outst_r) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            if (accept_s) recv_cnt_r <= recv_cnt_r + 16'd1;
        end
    end

    // Skid FIFO pointers and occupancy; a timeout discards everything buffered.
    always_ff @(posedge CLK) begin
        if (RESET || timeout_s) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Skid FIFO storage.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= fw_win_flat;
            fifo_last_r[wr_ptr_r] <= (recv_cnt_r == LAST_IDX);
            fifo_idx_r[wr_ptr_r]  <= recv_cnt_r;
        end
    end

    assign busy           = busy_r;
    assign layer_done     = layer_done_r;
    assign err_timeout    = err_timeout_r;
    assign err_seq        = err_seq_r;
    assign fw_start_frame = (state_r == START);
    assign fw_win_req     = issue_req_s;
    assign m_valid        = fifo_ne_s;
    assign m_data         = fifo_ne_s ? fifo_data_r[rd_ptr_r] : {WW{1'b0}};
    assign m_last         = fifo_ne_s ? fifo_last_r[rd_ptr_r] : 1'b0;
    assign m_win_idx      = fifo_ne_s ? fifo_idx_r[rd_ptr_r] : 16'd0;
endmodule

// File: tb/tb_conv1_window_scheduler.sv
// Bench for conv1_window_scheduler on an 8x8 image (16 windows/frame) with a behavioural
// 21-cycle fetcher and a scoreboard of expected windows checked at the stream output.
module tb_conv1_window_scheduler;
    localparam int WW = 216;
    localparam int LAT = 21;

    logic CLK, RESET, layer_start, busy, layer_done, err_timeout, err_seq;
    logic [7:0] num_frames;
    logic fw_start_frame, fw_win_req, fw_win_valid, fw_frame_done;
    logic [WW-1:0] fw_win_flat, m_data;
    logic m_valid, m_ready, m_last;
    logic [15:0] m_win_idx;

    typedef struct {
        logic [WW-1:0] d;
        logic          l;
        logic [15:0]   i;
    } exp_t;
    exp_t q[$];

    int n_pass = 0, n_chk = 0;
    int n_start, n_req, n_done, n_out, n_last, n_overlap, n_bad_start;
    int cyc = 0, req5_cyc, err_cyc;
    int rdy_mode, fd_idx, hang_req;
    int f_frame, f_idx, f_req, lat;
    logic pending;
    logic ok;

    conv1_window_scheduler #(
        .IMG_W(8), .IMG_H(8), .STRIDE(2), .A_BITS(8), .FIFO_DEPTH(2), .TIMEOUT(64)
    ) dut (
        .CLK(CLK), .RESET(RESET), .layer_start(layer_start), .num_frames(num_frames),
        .busy(busy), .layer_done(layer_done), .err_timeout(err_timeout), .err_seq(err_seq),
        .fw_start_frame(fw_start_frame), .fw_win_req(fw_win_req), .fw_win_valid(fw_win_valid),
        .fw_win_flat(fw_win_flat), .fw_frame_done(fw_frame_done), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_win_idx(m_win_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [WW-1:0] mkdata(input int fr, input int ix);
        logic [WW-1:0] d;
        d = '0;
        for (int c = 0; c < 27; c++) d[c*8 +: 8] = 8'((fr * 61 + ix * 7 + c * 3 + 1) & 255);
        return d;
    endfunction

    // Behavioural fetcher plus m_ready driver; expected windows are queued as they are produced.
    initial begin
        fw_win_valid = 1'b0; fw_frame_done = 1'b0; fw_win_flat = '0; m_ready = 1'b0;
        pending = 1'b0; lat = 0; f_frame = -1; f_idx = 0; f_req = 0;
        forever begin
            @(negedge CLK);
            if (RESET) pending = 1'b0;
            else begin
                if (fw_start_frame) begin f_frame++; f_idx = 0; end
                if (fw_win_req) begin
                    f_req++;
                    if (f_req != hang_req) begin pending = 1'b1; lat = LAT; end
                end
            end
            @(posedge CLK); #1;
            fw_win_valid = 1'b0; fw_frame_done = 1'b0;
            m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
            if (pending) begin
                lat--;
                if (lat == 0) begin
                    exp_t e;
                    pending = 1'b0;
                    fw_win_valid = 1'b1;
                    fw_win_flat = mkdata(f_frame, f_idx);
                    fw_frame_done = (f_idx == fd_idx);
                    e.d = fw_win_flat; e.l = (f_idx == 15); e.i = 16'(f_idx);
                    q.push_back(e);
                    f_idx++;
                end
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET) begin
                if (fw_start_frame) begin n_start++; if (m_valid) n_bad_start++; end
                if (fw_win_req) begin
                    n_req++;
                    if (n_req == 5) req5_cyc = cyc;
                    if (fw_win_valid) n_overlap++;
                end
                if (layer_done) n_done++;
                if (err_timeout && err_cyc < 0) err_cyc = cyc;
                if (m_valid && m_ready) begin
                    n_chk++;
                    if (q.size() == 0) $display("FAIL sb_unexpected: got idx %0d, want no window", m_win_idx);
                    else begin
                        e = q.pop_front();
                        if (m_data !== e.d || m_last !== e.l || m_win_idx !== e.i)
                            $display("FAIL sb_window: got idx %0d last %b data %h, want idx %0d last %b data %h",
                                     m_win_idx, m_last, m_data, e.i, e.l, e.d);
                        else n_pass++;
                    end
                    n_out++;
                    if (m_last) n_last++;
                end
            end
        end
    end

    task automatic prep(input int mode);
        rdy_mode = mode;
        n_start = 0; n_req = 0; n_done = 0; n_out = 0; n_last = 0; n_overlap = 0; n_bad_start = 0;
        req5_cyc = -1; err_cyc = -1; f_frame = -1; f_req = 0;
    endtask

    task automatic start_layer(input logic [7:0] nf);
        @(posedge CLK); #1;
        num_frames = nf; layer_start = 1'b1;
        @(posedge CLK); #1;
        layer_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!busy) begin done = 1'b1; break; end
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_chk++; if (layer_done !== 1'b0) $display("FAIL reset_layer_done: got %b want 0", layer_done); else n_pass++;
        n_chk++; if ({err_timeout, err_seq} !== 2'b00) $display("FAIL reset_errs: got %b want 00", {err_timeout, err_seq}); else n_pass++;
        n_chk++; if ({fw_start_frame, fw_win_req} !== 2'b00) $display("FAIL reset_fw: got %b want 00", {fw_start_frame, fw_win_req}); else n_pass++;
        n_chk++; if (m_data !== '0 || m_win_idx !== 16'd0 || m_last !== 1'b0) $display("FAIL reset_head: got idx %0d last %b want 0 0", m_win_idx, m_last); else n_pass++;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        prep(1);
        start_layer(8'd1);
        wait_idle(2000, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL basic_finish: got busy stuck, want idle"); else n_pass++;
        n_chk++; if (n_out != 16) $display("FAIL basic_count: got %0d want 16", n_out); else n_pass++;
        n_chk++; if (n_last != 1) $display("FAIL basic_last: got %0d want 1", n_last); else n_pass++;
        n_chk++; if (n_done != 1) $display("FAIL basic_done: got %0d want 1", n_done); else n_pass++;
        n_chk++; if (n_start != 1) $display("FAIL basic_start: got %0d want 1", n_start); else n_pass++;
        n_chk++; if ({err_timeout, err_seq} !== 2'b00) $display("FAIL basic_errs: got %b want 00", {err_timeout, err_seq}); else n_pass++;
        n_chk++; if (q.size() != 0) $display("FAIL basic_sb_left: got %0d want 0", q.size()); else n_pass++;
    endtask

    task automatic test_stall();
        prep(0);
        start_layer(8'd1);
        repeat (70) @(negedge CLK);
        n_chk++; if (n_req != 2) $display("FAIL stall_reqs: got %0d want 2", n_req); else n_pass++;
        n_chk++; if (q.size() != 2) $display("FAIL stall_fill: got %0d want 2", q.size()); else n_pass++;
        repeat (20) @(negedge CLK);
        n_chk++; if (n_req != 2) $display("FAIL stall_noreq: got %0d want 2", n_req); else n_pass++;
        n_chk++; if (m_valid !== 1'b1 || m_win_idx !== 16'd0 || m_last !== 1'b0) $display("FAIL stall_head: got v%b idx %0d last %b want v1 idx 0 last 0", m_valid, m_win_idx, m_last); else n_pass++;
        n_chk++; if (m_data !== mkdata(0, 0)) $display("FAIL stall_data: got %h want %h", m_data, mkdata(0, 0)); else n_pass++;
        rdy_mode = 1;
        wait_idle(2000, ok);
        n_chk++; if (n_out != 16 || n_done != 1) $display("FAIL stall_drain: got %0d windows %0d done want 16 1", n_out, n_done); else n_pass++;
        n_chk++; if (n_overlap != 0) $display("FAIL stall_overlap: got %0d want 0", n_overlap); else n_pass++;
    endtask

    task automatic test_multi_frame();
        prep(2);
        start_layer(8'd3);
        wait_idle(6000, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL multi_finish: got busy stuck, want idle"); else n_pass++;
        n_chk++; if (n_out != 48) $display("FAIL multi_count: got %0d want 48", n_out); else n_pass++;
        n_chk++; if (n_last != 3) $display("FAIL multi_last: got %0d want 3", n_last); else n_pass++;
        n_chk++; if (n_start != 3 || n_bad_start != 0) $display("FAIL multi_start: got %0d starts %0d nonempty want 3 0", n_start, n_bad_start); else n_pass++;
        n_chk++; if (n_done != 1) $display("FAIL multi_done: got %0d want 1", n_done); else n_pass++;
        n_chk++; if ({err_timeout, err_seq} !== 2'b00) $display("FAIL multi_errs: got %b want 00", {err_timeout, err_seq}); else n_pass++;
        prep(1);
        start_layer(8'd0);
        wait_idle(2000, ok);
        n_chk++; if (n_start != 1 || n_out != 16 || n_done != 1) $display("FAIL zero_frames: got %0d starts %0d windows %0d done want 1 16 1", n_start, n_out, n_done); else n_pass++;
    endtask

    task automatic test_frame_done_err();
        prep(1);
        fd_idx = 14;
        start_layer(8'd1);
        wait_idle(2000, ok);
        n_chk++; if (err_seq !== 1'b1) $display("FAIL fd_err_seq: got %b want 1", err_seq); else n_pass++;
        n_chk++; if (n_out != 16 || n_done != 1) $display("FAIL fd_flow: got %0d windows %0d done want 16 1", n_out, n_done); else n_pass++;
        repeat (10) @(negedge CLK);
        n_chk++; if (err_seq !== 1'b1 || err_timeout !== 1'b0) $display("FAIL fd_sticky: got seq %b tmo %b want 1 0", err_seq, err_timeout); else n_pass++;
        fd_idx = 15;
    endtask

    task automatic test_timeout();
        prep(1);
        hang_req = 5;
        start_layer(8'd1);
        wait_idle(2000, ok);
        n_chk++; if (err_timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", err_timeout); else n_pass++;
        n_chk++; if (err_cyc - req5_cyc != 64) $display("FAIL tmo_delay: got %0d want 64", err_cyc - req5_cyc); else n_pass++;
        n_chk++; if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL tmo_idle: got busy %b m_valid %b want 0 0", busy, m_valid); else n_pass++;
        n_chk++; if (n_done != 0) $display("FAIL tmo_no_done: got %0d want 0", n_done); else n_pass++;
        n_chk++; if (n_out != 4 || q.size() != 0) $display("FAIL tmo_windows: got %0d out %0d queued want 4 0", n_out, q.size()); else n_pass++;
        hang_req = 0;
        prep(1);
        start_layer(8'd1);
        @(negedge CLK);
        n_chk++; if (err_timeout !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_clear: got tmo %b busy %b want 0 1", err_timeout, busy); else n_pass++;
        wait_idle(2000, ok);
        n_chk++; if (n_out != 16 || n_done != 1 || err_timeout !== 1'b0) $display("FAIL tmo_restart: got %0d windows %0d done tmo %b want 16 1 0", n_out, n_done, err_timeout); else n_pass++;
    endtask

    task automatic test_reset_mid();
        prep(0);
        start_layer(8'd1);
        repeat (70) @(negedge CLK);
        n_chk++; if (m_valid !== 1'b1 || q.size() != 2) $display("FAIL mid_full: got v%b queued %0d want v1 2", m_valid, q.size()); else n_pass++;
        start_layer(8'd1);
        repeat (5) @(negedge CLK);
        n_chk++; if (n_start != 1) $display("FAIL mid_start_ignored: got %0d want 1", n_start); else n_pass++;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_chk++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_reset: got v%b busy %b want 0 0", m_valid, busy); else n_pass++;
        n_chk++; if (m_data !== '0 || m_win_idx !== 16'd0 || m_last !== 1'b0) $display("FAIL mid_head: got idx %0d last %b want 0 0", m_win_idx, m_last); else n_pass++;
        @(posedge CLK); #1;
        RESET = 1'b0;
        q.delete();
        prep(1);
        start_layer(8'd1);
        wait_idle(2000, ok);
        n_chk++; if (n_out != 16 || n_done != 1 || n_start != 1) $display("FAIL mid_rerun: got %0d windows %0d done %0d starts want 16 1 1", n_out, n_done, n_start); else n_pass++;
        n_chk++; if (n_overlap != 0) $display("FAIL overlap_total: got %0d want 0", n_overlap); else n_pass++;
    endtask

    initial begin
        RESET = 1'b1; layer_start = 1'b0; num_frames = 8'd0;
        rdy_mode = 1; fd_idx = 15; hang_req = 0;
        prep(1);
        test_reset();
        test_basic();
        test_stall();
        test_multi_frame();
        test_frame_done_err();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv1_window_scheduler.md
Name: conv1_window_scheduler

Overview:
Sequences the stride-2 3x3x3 int8 window fetcher for the first conv layer over one or more frames, and hands windows to the PE array over a valid/ready stream. Owns start_frame/win_req generation, window and frame counting, and a small skid FIFO so the fetcher prefetches while the array stalls. Also checks the fetcher's frame_done alignment and watches for a hung fetcher.

Parameters:
IMG_W, 224, input width in pixels
IMG_H, 224, input height in pixels
STRIDE, 2, conv stride; windows per frame NUM_WIN = (IMG_W/STRIDE)*(IMG_H/STRIDE)
A_BITS, 8, bits per channel; window width WW = 27*A_BITS
FIFO_DEPTH, 2, skid FIFO entries (power of two, >=1)
TIMEOUT, 64, max cycles from win_req pulse to fw_win_valid

Ports:
CLK  in  1  clock
RESET  in  1  reset
layer_start  in  1  pulse: begin layer; ignored while busy
num_frames  in  8  frames in layer, sampled on accepted layer_start; 0 treated as 1
busy  out  1  high from accepted layer_start until done/abort
layer_done  out  1  1-cycle pulse after last window of last frame is accepted downstream
err_timeout  out  1  sticky; cleared only by RESET or accepted layer_start
err_seq  out  1  sticky; frame_done misalignment; cleared as err_timeout
fw_start_frame  out  1  to fetcher start_frame
fw_win_req  out  1  to fetcher win_req
fw_win_valid  in  1  from fetcher win_valid
fw_win_flat  in  WW  from fetcher win_flat
fw_frame_done  in  1  from fetcher frame_done
m_valid  out  1  window available to PE array
m_ready  in  1  PE array accepts
m_data  out  WW  window, cin-fastest, unchanged from fetcher
m_last  out  1  with m_valid: last window of a frame
m_win_idx  out  16  window index within frame (0..NUM_WIN-1)

Behaviour:
- One clock; reset is synchronous and active-high. CLK/RESET only; the fetcher's own active-low reset is driven at top level, not here.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- States: IDLE, START, RUN, DRAIN.
- IDLE: layer_start -> latch num_frames (0->1), clear err flags, frame_cnt=0, busy=1, -> START.
- START: fw_start_frame=1 for exactly this cycle; zero issued/received counters; -> RUN. The first fw_win_req is allowed in the first RUN cycle.
- RUN: fw_win_req is a 1-cycle pulse when issue_cnt<NUM_WIN, outstanding==0, and fifo_count + outstanding < FIFO_DEPTH (pop in the same cycle does not count).
  - A pulse sets outstanding=1 and increments issue_cnt.
  - fw_win_valid clears outstanding, pushes {fw_win_flat, last=(recv_cnt==NUM_WIN-1), recv_cnt}, and increments recv_cnt.
  - No req in the same cycle as fw_win_valid; the earliest next req is the cycle after.
- fw_win_valid while outstanding==0: ignored (not pushed), err_seq=1.
- frame_done check: fw_frame_done must coincide with the fw_win_valid of recv_cnt==NUM_WIN-1. Any other fw_frame_done, or its absence on that valid, sets err_seq. Flow continues.
- RUN -> DRAIN when recv_cnt reaches NUM_WIN.
- DRAIN: wait for FIFO empty. Then:
  - if frame_cnt+1 < frames: frame_cnt++, -> START;
  - else layer_done=1 for one cycle, busy=0, -> IDLE.
- FIFO/stream:
  - m_valid = FIFO non-empty; m_data/m_last/m_win_idx come from the head.
  - Pop on m_valid&&m_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - Head fields hold stable while m_valid && !m_ready.
  - Overflow is impossible by the credit rule; if it occurs, assertion only.
  - m_data/m_last/m_win_idx read 0 when empty.
- Timeout: counter clears on fw_win_req and counts while outstanding. On reaching TIMEOUT:
  - err_timeout=1, FIFO flushed, outstanding cleared, busy=0, -> IDLE;
  - no layer_done.
- layer_start in any state other than IDLE is ignored.
- RESET mid-operation: immediate return to reset values; FIFO contents discarded.

Test Plan:
- IMG_W=IMG_H=8, STRIDE=2, num_frames=1, m_ready=1, behavioural fetcher (21-cycle latency) -> 16 windows, m_win_idx 0..15, m_last only on idx 15, one layer_done, err flags 0, exactly one fw_start_frame.
- Same config, m_ready held 0 -> FIFO fills to 2 with 0 outstanding and no further fw_win_req; on m_ready=1 windows 0..15 arrive in order with data intact; no req ever overlaps fw_win_valid.
- num_frames=3 with random m_ready (50%) -> 48 windows, three fw_start_frame pulses each preceded by an empty FIFO, m_last on every 16th, one layer_done; num_frames=0 behaves as 1.
- Fetcher raises fw_frame_done on window 14 instead of 15 -> err_seq=1 sticky, all 16 windows still delivered, layer_done asserted.
- Fetcher never answers the 5th request, TIMEOUT=64 -> err_timeout=1 exactly 64 cycles after that req, busy=0, FIFO empty, no layer_done; a new layer_start clears err_timeout and restarts from window 0.
- RESET asserted mid-frame with FIFO holding 2 entries -> next cycle m_valid=0, busy=0, counters 0; layer_start during busy produces no second start_frame.
